// File: rtl/id_stage_if.sv
// Bus between the IF/ID latch, write-back and hazard sources and the decode stage.
// The slave side is the decode stage; the master side is whatever surrounds it.
interface id_stage_if #(
  parameter int DATA_W = 32
);
  // IF/ID latch
  logic [31:0]       if_pc;
  logic [31:0]       if_instr;
  logic              if_valid;
  // write-back port
  logic              wb_en;
  logic [4:0]        wb_dest;
  logic [DATA_W-1:0] wb_value;
  // in-flight destinations for RAW detection
  logic              exe_wb_en;
  logic [4:0]        exe_dest;
  logic              mem_wb_en;
  logic [4:0]        mem_dest;
  // same-cycle controls back to fetch
  logic              hazard_stall;
  logic              br_taken;
  logic [31:0]       br_addr;
  // ID/EX pipeline register
  logic [31:0]       id_pc;
  logic [DATA_W-1:0] id_val1;
  logic [DATA_W-1:0] id_val2;
  logic [DATA_W-1:0] id_st_val;
  logic [4:0]        id_dest;
  logic [3:0]        id_exe_cmd;
  logic              id_mem_r;
  logic              id_mem_w;
  logic              id_wb_en;

  modport master (
    output if_pc, if_instr, if_valid, wb_en, wb_dest, wb_value,
           exe_wb_en, exe_dest, mem_wb_en, mem_dest,
    input  hazard_stall, br_taken, br_addr, id_pc, id_val1, id_val2,
           id_st_val, id_dest, id_exe_cmd, id_mem_r, id_mem_w, id_wb_en
  );

  modport slave (
    input  if_pc, if_instr, if_valid, wb_en, wb_dest, wb_value,
           exe_wb_en, exe_dest, mem_wb_en, mem_dest,
    output hazard_stall, br_taken, br_addr, id_pc, id_val1, id_val2,
           id_st_val, id_dest, id_exe_cmd, id_mem_r, id_mem_w, id_wb_en
  );
endinterface

// File: rtl/id_stage.sv
// MIPS decode stage: register file, BEQ/BNE/J resolution, RAW stall and ID/EX register.
// Defining ID_STATS_EN adds stat_stalls/stat_branches event counters.
module id_stage #(
  parameter int REG_COUNT = 32,
  parameter int DATA_W    = 32
) (
  input  logic        clk,
  input  logic        rst,
  id_stage_if.slave   bus
`ifdef ID_STATS_EN
  ,
  output logic [31:0] stat_stalls,
  output logic [31:0] stat_branches
`endif
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef enum logic [3:0] {
    CMD_ADD = 4'd0,
    CMD_SUB = 4'd1,
    CMD_AND = 4'd2,
    CMD_OR  = 4'd3,
    CMD_NOR = 4'd4,
    CMD_XOR = 4'd5,
    CMD_SLL = 4'd6,
    CMD_SRL = 4'd7,
    CMD_SRA = 4'd8
  } exe_cmd_e;

  typedef enum logic [3:0] {
    CLS_NOP,
    CLS_ALU_R,
    CLS_SHIFT,
    CLS_ADDI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_BNE,
    CLS_J
  } op_class_e;

  typedef struct packed {
    logic [31:0]       pc;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic [DATA_W-1:0] st_val;
    logic [4:0]        dest;
    exe_cmd_e          cmd;
    logic              mem_r;
    logic              mem_w;
    logic              wb_en;
  } idex_t;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [25:0] target;

  assign op     = bus.if_instr[31:26];
  assign rs     = bus.if_instr[25:21];
  assign rt     = bus.if_instr[20:16];
  assign rd     = bus.if_instr[15:11];
  assign shamt  = bus.if_instr[10:6];
  assign funct  = bus.if_instr[5:0];
  assign imm    = bus.if_instr[15:0];
  assign target = bus.if_instr[25:0];

  op_class_e cls;
  exe_cmd_e  dec_cmd;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cls     = CLS_NOP;
    dec_cmd = CMD_ADD;
    case (op)
      OP_RTYPE: begin
        case (funct)
          6'h20: begin cls = CLS_ALU_R; dec_cmd = CMD_ADD; end
          6'h22: begin cls = CLS_ALU_R; dec_cmd = CMD_SUB; end
          6'h24: begin cls = CLS_ALU_R; dec_cmd = CMD_AND; end
          6'h25: begin cls = CLS_ALU_R; dec_cmd = CMD_OR;  end
          6'h27: begin cls = CLS_ALU_R; dec_cmd = CMD_NOR; end
          6'h26: begin cls = CLS_ALU_R; dec_cmd = CMD_XOR; end
          6'h00: begin cls = CLS_SHIFT; dec_cmd = CMD_SLL; end
          6'h02: begin cls = CLS_SHIFT; dec_cmd = CMD_SRL; end
          6'h03: begin cls = CLS_SHIFT; dec_cmd = CMD_SRA; end
          default: ;
        endcase
      end
      OP_ADDI: cls = CLS_ADDI;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ:  cls = CLS_BEQ;
      OP_BNE:  cls = CLS_BNE;
      OP_J:    cls = CLS_J;
      default: ;
    endcase
  end

  logic [DATA_W-1:0] regs_q [REG_COUNT];

  // NOTE: the register file is reset deliberately: architectural state must read 0 after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (bus.wb_en && bus.wb_dest != 5'd0) begin
      regs_q[bus.wb_dest] <= bus.wb_value;
    end
  end

  // Read ports bypass the same-cycle write so decode never sees a stale value.
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;

  assign rs_val = (rs == 5'd0) ? '0 :
                  (bus.wb_en && bus.wb_dest == rs) ? bus.wb_value : regs_q[rs];
  assign rt_val = (rt == 5'd0) ? '0 :
                  (bus.wb_en && bus.wb_dest == rt) ? bus.wb_value : regs_q[rt];

  logic use_rs;
  logic use_rt;
  logic rs_hit;
  logic rt_hit;
  logic stall;

  assign use_rs = cls inside {CLS_ALU_R, CLS_ADDI, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE};
  assign use_rt = cls inside {CLS_ALU_R, CLS_SHIFT, CLS_SW, CLS_BEQ, CLS_BNE};

  assign rs_hit = (rs != 5'd0) &&
                  ((bus.exe_wb_en && bus.exe_dest == rs) || (bus.mem_wb_en && bus.mem_dest == rs));
  assign rt_hit = (rt != 5'd0) &&
                  ((bus.exe_wb_en && bus.exe_dest == rt) || (bus.mem_wb_en && bus.mem_dest == rt));

  // A pending producer wins over a same-cycle write-back to the same register.
  assign stall = bus.if_valid && ((use_rs && rs_hit) || (use_rt && rt_hit));

  logic        br_cond;
  logic        taken;
  logic [31:0] br_off;

  always_comb begin
    br_cond = 1'b0;
    case (cls)
      CLS_BEQ: br_cond = (rs_val == rt_val);
      CLS_BNE: br_cond = (rs_val != rt_val);
      CLS_J:   br_cond = 1'b1;
      default: ;
    endcase
  end

  assign br_off = {{14{imm[15]}}, imm, 2'b00};
  assign taken  = bus.if_valid && !stall && br_cond;

  assign bus.hazard_stall = stall;
  assign bus.br_taken     = taken;
  assign bus.br_addr      = !taken          ? 32'd0 :
                            (cls == CLS_J)  ? {bus.if_pc[31:28], target, 2'b00} :
                                              bus.if_pc + br_off;

  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] shamt_zext;

  assign imm_sext   = {{(DATA_W-16){imm[15]}}, imm};
  assign shamt_zext = {{(DATA_W-5){1'b0}}, shamt};

  idex_t idex_d;
  idex_t idex_q;

  // Branches, J, NOPs, stalls and empty slots all leave an all-zero bubble.
  always_comb begin
    idex_d = '0;
    if (bus.if_valid && !stall) begin
      case (cls)
        CLS_ALU_R: begin
          idex_d.pc    = bus.if_pc;
          idex_d.val1  = rs_val;
          idex_d.val2  = rt_val;
          idex_d.dest  = rd;
          idex_d.cmd   = dec_cmd;
          idex_d.wb_en = 1'b1;
        end
        CLS_SHIFT: begin
          idex_d.pc    = bus.if_pc;
          idex_d.val1  = rt_val;
          idex_d.val2  = shamt_zext;
          idex_d.dest  = rd;
          idex_d.cmd   = dec_cmd;
          idex_d.wb_en = 1'b1;
        end
        CLS_ADDI, CLS_LW: begin
          idex_d.pc    = bus.if_pc;
          idex_d.val1  = rs_val;
          idex_d.val2  = imm_sext;
          idex_d.dest  = rt;
          idex_d.cmd   = CMD_ADD;
          idex_d.mem_r = (cls == CLS_LW);
          idex_d.wb_en = 1'b1;
        end
        CLS_SW: begin
          idex_d.pc     = bus.if_pc;
          idex_d.val1   = rs_val;
          idex_d.val2   = imm_sext;
          idex_d.st_val = rt_val;
          idex_d.cmd    = CMD_ADD;
          idex_d.mem_w  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  assign bus.id_pc      = idex_q.pc;
  assign bus.id_val1    = idex_q.val1;
  assign bus.id_val2    = idex_q.val2;
  assign bus.id_st_val  = idex_q.st_val;
  assign bus.id_dest    = idex_q.dest;
  assign bus.id_exe_cmd = idex_q.cmd;
  assign bus.id_mem_r   = idex_q.mem_r;
  assign bus.id_mem_w   = idex_q.mem_w;
  assign bus.id_wb_en   = idex_q.wb_en;

`ifdef ID_STATS_EN
  logic [31:0] stat_stalls_q;
  logic [31:0] stat_branches_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_stalls_q   <= '0;
      stat_branches_q <= '0;
    end else begin
      if (stall) stat_stalls_q   <= stat_stalls_q + 32'd1;
      if (taken) stat_branches_q <= stat_branches_q + 32'd1;
    end
  end

  assign stat_stalls   = stat_stalls_q;
  assign stat_branches = stat_branches_q;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed vectors push hand-computed expectations,
// a negedge monitor pops them and compares the same-cycle and the registered outputs.
`timescale 1ns/1ps
module tb_id_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_if bus ();

`ifdef ID_STATS_EN
  logic [31:0] stat_stalls;
  logic [31:0] stat_branches;
`endif

  id_stage dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus)
`ifdef ID_STATS_EN
    ,
    .stat_stalls   (stat_stalls),
    .stat_branches (stat_branches)
`endif
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_dest;
    logic [31:0] wb_value;
    logic        exe_en;
    logic [4:0]  exe_dest;
    logic        mem_en;
    logic [4:0]  mem_dest;
  } stim_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] st;
    logic [4:0]  dest;
    logic [3:0]  cmd;
    logic        mr;
    logic        mw;
    logic        wb;
  } idex_t;

  typedef struct {
    int          tag;
    logic        stall;
    logic        taken;
    logic [31:0] addr;
    idex_t       r;
  } exp_t;

  localparam idex_t BUB = '0;

  exp_t sb_q[$];
  exp_t prev;
  bit   prev_valid = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   vec_n  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_idex(input string pfx, input idex_t e);
    check({pfx, " id_pc"},      bus.id_pc,               e.pc);
    check({pfx, " id_val1"},    bus.id_val1,             e.v1);
    check({pfx, " id_val2"},    bus.id_val2,             e.v2);
    check({pfx, " id_st_val"},  bus.id_st_val,           e.st);
    check({pfx, " id_dest"},    32'(bus.id_dest),        32'(e.dest));
    check({pfx, " id_exe_cmd"}, 32'(bus.id_exe_cmd),     32'(e.cmd));
    check({pfx, " id_mem_r"},   32'(bus.id_mem_r),       32'(e.mr));
    check({pfx, " id_mem_w"},   32'(bus.id_mem_w),       32'(e.mw));
    check({pfx, " id_wb_en"},   32'(bus.id_wb_en),       32'(e.wb));
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic stim_t stim(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                                 input logic wb, input logic [4:0] wd, input logic [31:0] wv,
                                 input logic ee, input logic [4:0] ed,
                                 input logic me, input logic [4:0] md);
    stim_t s;
    s.valid = v;  s.pc = pc;  s.instr = instr;
    s.wb_en = wb; s.wb_dest = wd; s.wb_value = wv;
    s.exe_en = ee; s.exe_dest = ed; s.mem_en = me; s.mem_dest = md;
    return s;
  endfunction

  function automatic stim_t plain(input logic [31:0] pc, input logic [31:0] instr);
    return stim(1'b1, pc, instr, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
  endfunction

  function automatic idex_t rx(input logic [31:0] pc, input logic [31:0] v1, input logic [31:0] v2,
                               input logic [31:0] st, input logic [4:0] dest, input logic [3:0] cmd,
                               input logic mr, input logic mw, input logic wb);
    idex_t r;
    r.pc = pc; r.v1 = v1; r.v2 = v2; r.st = st; r.dest = dest;
    r.cmd = cmd; r.mr = mr; r.mw = mw; r.wb = wb;
    return r;
  endfunction

  task automatic step(input stim_t s, input logic stall, input logic taken,
                      input logic [31:0] addr, input idex_t r);
    exp_t e;
    @(posedge clk);
    #1;
    bus.if_valid  = s.valid;  bus.if_pc    = s.pc;       bus.if_instr = s.instr;
    bus.wb_en     = s.wb_en;  bus.wb_dest  = s.wb_dest;  bus.wb_value = s.wb_value;
    bus.exe_wb_en = s.exe_en; bus.exe_dest = s.exe_dest;
    bus.mem_wb_en = s.mem_en; bus.mem_dest = s.mem_dest;
    vec_n++;
    e.tag = vec_n; e.stall = stall; e.taken = taken; e.addr = addr; e.r = r;
    sb_q.push_back(e);
  endtask

  // Monitor: at each negedge the combinational outputs belong to the vector now driven,
  // the ID/EX outputs to the vector driven one cycle earlier.
  initial begin : monitor
    exp_t cur;
    forever begin
      @(negedge clk);
      if (prev_valid) check_idex($sformatf("v%0d", prev.tag), prev.r);
      if (sb_q.size() > 0) begin
        cur = sb_q.pop_front();
        check($sformatf("v%0d hazard_stall", cur.tag), 32'(bus.hazard_stall), 32'(cur.stall));
        check($sformatf("v%0d br_taken", cur.tag),     32'(bus.br_taken),     32'(cur.taken));
        check($sformatf("v%0d br_addr", cur.tag),      bus.br_addr,           cur.addr);
        prev       = cur;
        prev_valid = 1'b1;
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  initial begin : driver
`ifdef ID_STATS_EN
    logic [31:0] cnt0;
`endif
    rst = 1'b1;
    bus.if_valid = 1'b0; bus.if_pc = '0; bus.if_instr = '0;
    bus.wb_en = 1'b0; bus.wb_dest = '0; bus.wb_value = '0;
    bus.exe_wb_en = 1'b0; bus.exe_dest = '0; bus.mem_wb_en = 1'b0; bus.mem_dest = '0;
    #3;
    check_idex("por", BUB);
    check("por br_taken", 32'(bus.br_taken), 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // v1 idle slot
    step(stim(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0), 1'b0, 1'b0, 32'h0, BUB);
    // v2 write-through: r3 <= DEADBEEF while ADD r1,r3,r0 decodes
    step(stim(1'b1, 32'h4, enc_r(5'd3, 5'd0, 5'd1, 5'd0, 6'h20), 1'b1, 5'd3, 32'hDEADBEEF,
              1'b0, 5'd0, 1'b0, 5'd0),
         1'b0, 1'b0, 32'h0, rx(32'h4, 32'hDEADBEEF, 32'h0, 32'h0, 5'd1, 4'd0, 1'b0, 1'b0, 1'b1));
    // v3 write to r0 ignored; ADD r2,r0,r0
    step(stim(1'b1, 32'h8, enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'h20), 1'b1, 5'd0, 32'hFFFFFFFF,
              1'b0, 5'd0, 1'b0, 5'd0),
         1'b0, 1'b0, 32'h0, rx(32'h8, 32'h0, 32'h0, 32'h0, 5'd2, 4'd0, 1'b0, 1'b0, 1'b1));
    // v4 ADDI r5,r3,-1 ; r1 <= 7
    step(stim(1'b1, 32'hC, enc_i(6'h08, 5'd3, 5'd5, 16'hFFFF), 1'b1, 5'd1, 32'd7,
              1'b0, 5'd0, 1'b0, 5'd0),
         1'b0, 1'b0, 32'h0, rx(32'hC, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h0, 5'd5, 4'd0, 1'b0, 1'b0, 1'b1));
    // v5 SW r1,0x10(r3) ; r2 <= 7
    step(stim(1'b1, 32'h10, enc_i(6'h2B, 5'd3, 5'd1, 16'h0010), 1'b1, 5'd2, 32'd7,
              1'b0, 5'd0, 1'b0, 5'd0),
         1'b0, 1'b0, 32'h0, rx(32'h10, 32'hDEADBEEF, 32'h10, 32'd7, 5'd0, 4'd0, 1'b0, 1'b1, 1'b0));
    // v6 BEQ r1,r2,-2 taken (7==7) ; r7 <= 0x30
    step(stim(1'b1, 32'h100, enc_i(6'h04, 5'd1, 5'd2, 16'hFFFE), 1'b1, 5'd7, 32'h30,
              1'b0, 5'd0, 1'b0, 5'd0),
         1'b0, 1'b1, 32'hF8, BUB);
    // v7 same BEQ while r2 <= 8 is written through: not taken
    step(stim(1'b1, 32'h100, enc_i(6'h04, 5'd1, 5'd2, 16'hFFFE), 1'b1, 5'd2, 32'd8,
              1'b0, 5'd0, 1'b0, 5'd0),
         1'b0, 1'b0, 32'h0, BUB);
    // v8 BNE r1,r2,+3 taken (7!=8) ; r4 <= 0x50
    step(stim(1'b1, 32'h200, enc_i(6'h05, 5'd1, 5'd2, 16'h0003), 1'b1, 5'd4, 32'h50,
              1'b0, 5'd0, 1'b0, 5'd0),
         1'b0, 1'b1, 32'h20C, BUB);
    // v9 J 0x40
    step(plain(32'h40000010, {6'h02, 26'h0000040}), 1'b0, 1'b1, 32'h40000100, BUB);
`ifdef ID_STATS_EN
    cnt0 = stat_branches;
`endif
    // v10 load-use on r4 from EXE: SUB r6,r4,r7 stalls
    step(stim(1'b1, 32'h300, enc_r(5'd4, 5'd7, 5'd6, 5'd0, 6'h22), 1'b0, 5'd0, 32'h0,
              1'b1, 5'd4, 1'b0, 5'd0),
         1'b1, 1'b0, 32'h0, BUB);
`ifdef ID_STATS_EN
    check("stat_branches after J", stat_branches, cnt0 + 32'd1);
    cnt0 = stat_stalls;
`endif
    // v11 producer gone: SUB issues
    step(plain(32'h300, enc_r(5'd4, 5'd7, 5'd6, 5'd0, 6'h22)),
         1'b0, 1'b0, 32'h0, rx(32'h300, 32'h50, 32'h30, 32'h0, 5'd6, 4'd1, 1'b0, 1'b0, 1'b1));
`ifdef ID_STATS_EN
    check("stat_stalls after load-use", stat_stalls, cnt0 + 32'd1);
`endif
    // v12 SLL r9,r7,4 with rs field = r5 busy in EXE: shifts ignore rs
    step(stim(1'b1, 32'h304, enc_r(5'd5, 5'd7, 5'd9, 5'd4, 6'h00), 1'b0, 5'd0, 32'h0,
              1'b1, 5'd5, 1'b0, 5'd0),
         1'b0, 1'b0, 32'h0, rx(32'h304, 32'h30, 32'd4, 32'h0, 5'd9, 4'd6, 1'b0, 1'b0, 1'b1));
    // v13 SRA r9,r7,2: MEM hazard on r7 beats same-cycle write-back r7 <= 0x99
    step(stim(1'b1, 32'h308, enc_r(5'd0, 5'd7, 5'd9, 5'd2, 6'h03), 1'b1, 5'd7, 32'h99,
              1'b0, 5'd0, 1'b1, 5'd7),
         1'b1, 1'b0, 32'h0, BUB);
    // v14 EXE writes r0: never a hazard
    step(stim(1'b1, 32'h30C, enc_r(5'd0, 5'd0, 5'd10, 5'd0, 6'h20), 1'b0, 5'd0, 32'h0,
              1'b1, 5'd0, 1'b0, 5'd0),
         1'b0, 1'b0, 32'h0, rx(32'h30C, 32'h0, 32'h0, 32'h0, 5'd10, 4'd0, 1'b0, 1'b0, 1'b1));
    // v15 unknown opcode: NOP, no sources, no stall
    step(stim(1'b1, 32'h310, enc_i(6'h3F, 5'd1, 5'd2, 16'h1234), 1'b0, 5'd0, 32'h0,
              1'b1, 5'd1, 1'b0, 5'd0),
         1'b0, 1'b0, 32'h0, BUB);
    // v16 bubble holding a BEQ with a hazard: nothing happens
    step(stim(1'b0, 32'h314, enc_i(6'h04, 5'd1, 5'd1, 16'h0004), 1'b0, 5'd0, 32'h0,
              1'b1, 5'd1, 1'b0, 5'd0),
         1'b0, 1'b0, 32'h0, BUB);
    // v17 XOR r11,r7,r1
    step(plain(32'h400, enc_r(5'd7, 5'd1, 5'd11, 5'd0, 6'h26)),
         1'b0, 1'b0, 32'h0, rx(32'h400, 32'h99, 32'd7, 32'h0, 5'd11, 4'd5, 1'b0, 1'b0, 1'b1));
    // v18 LW r12,-4(r2)
    step(plain(32'h404, enc_i(6'h23, 5'd2, 5'd12, 16'hFFFC)),
         1'b0, 1'b0, 32'h0, rx(32'h404, 32'd8, 32'hFFFFFFFC, 32'h0, 5'd12, 4'd0, 1'b1, 1'b0, 1'b1));
    // v19 BEQ r1,r1 with r1 busy in EXE: stall suppresses the redirect
    step(stim(1'b1, 32'h408, enc_i(6'h04, 5'd1, 5'd1, 16'h0004), 1'b0, 5'd0, 32'h0,
              1'b1, 5'd1, 1'b0, 5'd0),
         1'b1, 1'b0, 32'h0, BUB);
    // v20 NOR r13,r1,r2
    step(plain(32'h40C, enc_r(5'd1, 5'd2, 5'd13, 5'd0, 6'h27)),
         1'b0, 1'b0, 32'h0, rx(32'h40C, 32'd7, 32'd8, 32'h0, 5'd13, 4'd4, 1'b0, 1'b0, 1'b1));
    // v21 R-type with unknown funct 0x21: NOP, no stall despite EXE on r1
    step(stim(1'b1, 32'h410, enc_r(5'd1, 5'd2, 5'd14, 5'd0, 6'h21), 1'b0, 5'd0, 32'h0,
              1'b1, 5'd1, 1'b0, 5'd0),
         1'b0, 1'b0, 32'h0, BUB);
    // v22 ADD r13,r1,r1 ; r5 <= 0x1234
    step(stim(1'b1, 32'h500, enc_r(5'd1, 5'd1, 5'd13, 5'd0, 6'h20), 1'b1, 5'd5, 32'h1234,
              1'b0, 5'd0, 1'b0, 5'd0),
         1'b0, 1'b0, 32'h0, rx(32'h500, 32'd7, 32'd7, 32'h0, 5'd13, 4'd0, 1'b0, 1'b0, 1'b1));
    // v23 idle; its negedge still shows v22's id_wb_en = 1
    step(stim(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0), 1'b0, 1'b0, 32'h0, BUB);

    // Mid-run asynchronous reset: ID/EX clears without a clock edge.
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check_idex("midrst", BUB);
    prev_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b0;

    // v24 ADD r14,r5,r0: r5 was cleared by reset
    step(plain(32'h600, enc_r(5'd5, 5'd0, 5'd14, 5'd0, 6'h20)),
         1'b0, 1'b0, 32'h0, rx(32'h600, 32'h0, 32'h0, 32'h0, 5'd14, 4'd0, 1'b0, 1'b0, 1'b1));
    // v25 idle
    step(stim(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0), 1'b0, 1'b0, 32'h0, BUB);

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage sitting directly downstream of the fetch stage in the 5-stage MIPS pipeline.
- Consumes the fetched PC+4 and instruction (via the IF/ID latch) and contains the 32x32 register file.
- Resolves BEQ/BNE/J and drives the branch redirect (taken flag and target address) back to fetch.
- Detects RAW hazards against EXE/MEM, drives a stall, and registers decoded operands/controls into the ID/EX pipeline register.

Parameters:
- REG_COUNT, 32, number of architectural registers (r0 hardwired 0)
- DATA_W, 32, datapath width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- if_pc  in  32  PC+4 of the instruction in IF/ID
- if_instr  in  32  instruction in IF/ID
- if_valid  in  1  IF/ID holds a real instruction (0 = bubble)
- wb_en  in  1  write-back enable
- wb_dest  in  5  write-back register index
- wb_value  in  32  write-back data
- exe_wb_en  in  1  instruction in EXE writes a register
- exe_dest  in  5  EXE destination
- mem_wb_en  in  1  instruction in MEM writes a register
- mem_dest  in  5  MEM destination
- hazard_stall  out  1  hold PC and IF/ID this cycle (combinational)
- br_taken  out  1  redirect fetch (combinational)
- br_addr  out  32  fetch target address (combinational)
- id_pc  out  32  registered PC+4
- id_val1  out  32  registered operand 1 (rs value)
- id_val2  out  32  registered operand 2 (rt value, or immediate)
- id_st_val  out  32  registered rt value for SW
- id_dest  out  5  registered destination index
- id_exe_cmd  out  4  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 XOR, 6 SLL, 7 SRL, 8 SRA
- id_mem_r  out  1  load
- id_mem_w  out  1  store
- id_wb_en  out  1  register write-back

Behaviour:
- Reset (asynchronous): all 32 registers cleared; every id_* output is 0. Combinational outputs follow from the cleared state.
- Decoded ops:
  - R-type (op 0x00), funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x26 XOR, 0x00 SLL, 0x02 SRL, 0x03 SRA.
  - ADDI 0x08, LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, J 0x02.
  - Any other opcode/funct decodes as a NOP (all controls 0).
- Destination: rd for R-type; rt for ADDI/LW.
- id_val2 by op class:
  - R-type (except shifts): rt value.
  - ADDI, LW, SW: sign-extended imm16.
  - SLL/SRL/SRA: zero-extended shamt; id_val1 = rt value.
- Register file:
  - 2 read ports, combinational; write on rising edge when wb_en and wb_dest != 0.
  - Writes to r0 are ignored; r0 always reads 0.
  - Write-through: if wb_en, wb_dest == read index, and index != 0, the read returns wb_value in the same cycle.
- Sources:
  - src1 = rs for all ops except shifts (none).
  - src2 = rt for R-type, SW, BEQ, BNE.
  - J uses no sources.
- Hazard:
  - hazard_stall = if_valid AND a used src != 0 AND it matches (exe_wb_en & exe_dest) or (mem_wb_en & mem_dest).
  - On hazard the ID/EX register loads a bubble: all controls and id_dest = 0; data outputs don't-care but driven 0.
- Branch:
  - br_taken = if_valid & ~hazard_stall & (BEQ & v1==v2 | BNE & v1!=v2 | J).
  - br_addr for BEQ/BNE = if_pc + (sext(imm16) << 2), modulo 2^32.
  - br_addr for J = {if_pc[31:28], target26, 2'b00}.
  - br_addr is 0 when br_taken = 0.
  - Branches and J write the ID/EX register as a bubble (no wb, no mem). Flushing the delay-slot instruction in IF/ID is the IF/ID latch's job, on br_taken.
- if_valid = 0: bubble into ID/EX, hazard_stall = 0, br_taken = 0.
- Latency: decode to ID/EX outputs is 1 cycle. Redirect and stall are same-cycle combinational.
- Simultaneous write-back and hazard on the same register: the hazard takes precedence, so the stall is raised even though a write-through value is available.

Optional Feature:
- Macro ID_STATS_EN.
- Defined:
  - Adds outputs stat_stalls[31:0] and stat_branches[31:0], both reset to 0.
  - stat_stalls increments every cycle hazard_stall = 1.
  - stat_branches increments every cycle br_taken = 1.
  - Both wrap at 2^32.
- Undefined: neither port nor counter exists; the module is otherwise identical.

Test Plan:
- Reset mid-run: assert rst while r5 = 0x1234 and id_wb_en = 1 -> all id_* = 0 immediately, and r5 then reads 0.
- Write-through: wb_en=1, wb_dest=3, wb_value=0xDEADBEEF, with ADD r1,r3,r0 in ID -> next cycle id_val1 = 0xDEADBEEF, id_exe_cmd = 0, id_dest = 1.
- r0 protection: write 0xFFFFFFFF to r0, then ADD r2,r0,r0 -> id_val1 = id_val2 = 0.
- Load-use: exe_wb_en=1, exe_dest=4, ID holds SUB r6,r4,r7 -> hazard_stall = 1 and ID/EX bubble; drop exe_wb_en -> stall 0, id_exe_cmd = 1.
- BEQ taken: r1 = r2 = 7, if_pc = 0x100, imm = 0xFFFE -> br_taken = 1, br_addr = 0xF8, ID/EX bubble. With r2 = 8 -> br_taken = 0.
- J with if_pc = 0x40000010, target = 0x0000040 -> br_addr = 0x40000100. Under ID_STATS_EN, stat_branches increments by 1.
